// File: rtl/adc_responder.sv
// adc_responder
// Behavioural stand-in for an 8-channel, 12-bit SPI ADC (LTC2308-style).
// It answers an external ADC master: a CONVST pulse starts a conversion,
// then 12 SCK cycles shift the result out on SDO while a 6-bit config word
// arrives on SDI. That config word selects the channel and coding for the
// *next* conversion.
//
// Ports
//   clk         system clock; every flop uses its rising edge
//   reset_n     synchronous, active-low reset
//   ch_values   eight 12-bit channel values, channel n at [12n+11:12n]
//   ADC_CONVST  conversion start from the master (asynchronous pin)
//   ADC_SCK     serial clock from the master (asynchronous pin)
//   ADC_SDI     config bits from the master, MSB first (asynchronous pin)
//   ADC_SDO     result bits to the master, MSB first
//   cfg_chan    channel decoded from the last complete frame
//   cfg_valid   one-cycle pulse when a complete frame is accepted
//   frame_err   one-cycle pulse when a frame is aborted by an early CONVST
//
// Handshake: there is no valid/ready pair. The master owns the timing. It
// starts a frame with a CONVST rise, starts shifting with the CONVST fall,
// and shifts 12 bits on SCK. SDO changes on the synchronized SCK fall, so the
// master can sample it on the SCK rise. Each SCK phase must last at least
// 4 clk cycles.
module adc_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [95:0] ch_values,
    input  logic        ADC_CONVST,
    input  logic        ADC_SCK,
    input  logic        ADC_SDI,
    output logic        ADC_SDO,
    output logic [2:0]  cfg_chan,
    output logic        cfg_valid,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Synchronizer chains. In each stage the bit order is {CONVST, SCK, SDI}.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [1:0]  prev_q;              // last synchronized {CONVST, SCK}
    logic [2:0]  pins_s;

    logic [1:0]  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  cfg_sr_q, cfg_sr_d;
    logic [11:0] result_q, result_d;
    logic [2:0]  chan_q, chan_d;
    logic        uni_q, uni_d;
    logic [2:0]  cfg_chan_q, cfg_chan_d;
    logic        cfg_valid_q, cfg_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        sdo_q, sdo_d;

    logic        conv_rise, conv_fall, sck_rise, sck_fall;
    logic [6:0]  sel_base;
    logic [11:0] latch_val;
    logic [2:0]  dec_chan;

    always_comb begin
        sync_d[0] = {ADC_CONVST, ADC_SCK, ADC_SDI};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign pins_s    = sync_q[SYNC_STAGES-1];
    assign conv_rise =  pins_s[2] & ~prev_q[1];
    assign conv_fall = ~pins_s[2] &  prev_q[1];
    assign sck_rise  =  pins_s[1] & ~prev_q[0];
    assign sck_fall  = ~pins_s[1] &  prev_q[0];

    // The bit offset of the selected channel is chan*12, computed as
    // chan*8 + chan*4.
    assign sel_base  = {1'b0, chan_q, 3'b000} + {2'b00, chan_q, 2'b00};
    // Bipolar coding flips the MSB. This turns offset binary into two's
    // complement.
    assign latch_val = ch_values[sel_base +: 12] ^ (uni_q ? 12'h000 : 12'h800);

    // Config word layout is {S/D, O/S, S1, S0, UNI, SLP}. SLP has no effect
    // here. In differential mode O/S is forced to 0 in the channel number.
    assign dec_chan  = cfg_sr_q[5] ? {cfg_sr_q[3], cfg_sr_q[2], cfg_sr_q[4]}
                                   : {cfg_sr_q[3], cfg_sr_q[2], 1'b0};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cfg_sr_d    = cfg_sr_q;
        result_d    = result_q;
        chan_d      = chan_q;
        uni_d       = uni_q;
        cfg_chan_d  = cfg_chan_q;
        cfg_valid_d = 1'b0;
        frame_err_d = 1'b0;
        sdo_d       = sdo_q;
        case (state_q)
            ST_IDLE: begin
                if (conv_rise) begin
                    result_d = latch_val;
                    state_d  = ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                    cfg_sr_d  = 6'd0;
                    sdo_d     = result_q[11];
                end
            end
            ST_SHIFT: begin
                // A CONVST rise takes priority over any SCK edge in the
                // same cycle. It aborts the frame, and the partial config
                // is discarded.
                if (conv_rise) begin
                    frame_err_d = 1'b1;
                    result_d    = latch_val;
                    state_d     = ST_CONV;
                    sdo_d       = 1'b0;
                end else if (sck_rise) begin
                    if (bit_cnt_q < 4'd6) begin
                        cfg_sr_d = {cfg_sr_q[4:0], pins_s[0]};
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd11) begin
                        state_d = ST_DONE;
                        sdo_d   = 1'b0;
                    end
                end else if (sck_fall && bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd11) begin
                    sdo_d = result_q[4'd11 - bit_cnt_q];
                end
            end
            ST_DONE: begin
                chan_d      = dec_chan;
                uni_d       = cfg_sr_q[1];
                cfg_chan_d  = dec_chan;
                cfg_valid_d = 1'b1;
                sdo_d       = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sdo_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q      <= '0;
            prev_q      <= 2'b00;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            cfg_sr_q    <= 6'd0;
            result_q    <= 12'd0;
            chan_q      <= 3'd0;
            uni_q       <= 1'b1;
            cfg_chan_q  <= 3'd0;
            cfg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            sdo_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= pins_s[2:1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cfg_sr_q    <= cfg_sr_d;
            result_q    <= result_d;
            chan_q      <= chan_d;
            uni_q       <= uni_d;
            cfg_chan_q  <= cfg_chan_d;
            cfg_valid_q <= cfg_valid_d;
            frame_err_q <= frame_err_d;
            sdo_q       <= sdo_d;
        end
    end

    assign ADC_SDO   = sdo_q;
    assign cfg_chan  = cfg_chan_q;
    assign cfg_valid = cfg_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed testbench for adc_responder. A master model drives CONVST/SCK/SDI
// with 6-clk phases and captures SDO just before each SCK rise. Background
// counters record cfg_valid and frame_err pulses.
module tb_adc_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [95:0] ch_values = '0;
    logic        ADC_CONVST = 1'b0;
    logic        ADC_SCK = 1'b0;
    logic        ADC_SDI = 1'b0;
    logic        ADC_SDO;
    logic [2:0]  cfg_chan;
    logic        cfg_valid;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    adc_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ch_values  (ch_values),
        .ADC_CONVST (ADC_CONVST),
        .ADC_SCK    (ADC_SCK),
        .ADC_SDI    (ADC_SDI),
        .ADC_SDO    (ADC_SDO),
        .cfg_chan   (cfg_chan),
        .cfg_valid  (cfg_valid),
        .frame_err  (frame_err)
    );

    // Clock / pulse monitors
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        err_cnt   = 0;
    endtask

    task automatic set_ch(input int n, input logic [11:0] v);
        ch_values[n*12 +: 12] = v;
    endtask

    // One frame of the master. After the CONVST fall it optionally loads
    // ch_mid to show that the frame in progress ignores the new values.
    task automatic run_frame(input logic [5:0] cfg, input int n_rises,
                             input bit use_mid, input logic [95:0] ch_mid,
                             output logic [11:0] sdo_word);
        sdo_word = '0;
        @(negedge clk);
        ADC_CONVST = 1'b1;
        wait_clks(6);
        ADC_CONVST = 1'b0;
        wait_clks(6);
        if (use_mid) ch_values = ch_mid;
        for (int i = 0; i < n_rises; i++) begin
            ADC_SDI = (i < 6) ? cfg[5-i] : 1'b0;
            wait_clks(6);
            if (i < 12) sdo_word[11-i] = ADC_SDO;
            ADC_SCK = 1'b1;
            wait_clks(6);
            ADC_SCK = 1'b0;
        end
        ADC_SDI = 1'b0;
        wait_clks(6);
    endtask

    // Scenario tasks
    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(4);
        checks++; if (ADC_SDO !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b want 0", ADC_SDO); end
        checks++; if (cfg_chan !== 3'd0) begin errors++; $display("FAIL reset_cfg_chan: got %0d want 0", cfg_chan); end
        checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_cfg_valid: got %b want 0", cfg_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset_n = 1'b1;
        wait_clks(4);
    endtask

    task automatic test_basic();
        logic [11:0] w;
        set_ch(0, 12'hA5C);
        clear_counts();
        run_frame(6'b100010, 12, 1'b0, '0, w);
        checks++; if (w !== 12'hA5C) begin errors++; $display("FAIL basic_sdo: got %h want a5c", w); end
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL basic_valid_pulses: got %0d want 1", valid_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL basic_err_pulses: got %0d want 0", err_cnt); end
        checks++; if (cfg_chan !== 3'd0) begin errors++; $display("FAIL basic_cfg_chan: got %0d want 0", cfg_chan); end
        checks++; if (ADC_SDO !== 1'b0) begin errors++; $display("FAIL basic_sdo_idle: got %b want 0", ADC_SDO); end
    endtask

    task automatic test_chan_select();
        logic [11:0] w;
        logic [95:0] mid;
        set_ch(1, 12'h123);
        run_frame(6'b110010, 12, 1'b0, '0, w);
        checks++; if (w !== 12'hA5C) begin errors++; $display("FAIL sel_pipeline_sdo: got %h want a5c", w); end
        checks++; if (cfg_chan !== 3'd1) begin errors++; $display("FAIL sel_cfg_chan: got %0d want 1", cfg_chan); end
        mid = ch_values;
        mid[23:12] = 12'hEEE;
        run_frame(6'b100010, 12, 1'b1, mid, w);
        checks++; if (w !== 12'h123) begin errors++; $display("FAIL sel_ch1_sdo: got %h want 123", w); end
        checks++; if (cfg_chan !== 3'd0) begin errors++; $display("FAIL sel_back_chan: got %0d want 0", cfg_chan); end
    endtask

    task automatic test_bipolar();
        logic [11:0] w;
        set_ch(0, 12'h000);
        run_frame(6'b100000, 12, 1'b0, '0, w);
        checks++; if (w !== 12'h000) begin errors++; $display("FAIL bip_first_sdo: got %h want 000", w); end
        run_frame(6'b100010, 12, 1'b0, '0, w);
        checks++; if (w !== 12'h800) begin errors++; $display("FAIL bip_offset_sdo: got %h want 800", w); end
    endtask

    task automatic test_abort();
        logic [11:0] w;
        set_ch(1, 12'h3C7);
        run_frame(6'b110010, 12, 1'b0, '0, w);
        checks++; if (w !== 12'h000) begin errors++; $display("FAIL abort_pre_sdo: got %h want 000", w); end
        clear_counts();
        run_frame(6'b100010, 5, 1'b0, '0, w);
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL abort_early_err: got %0d want 0", err_cnt); end
        run_frame(6'b100010, 12, 1'b0, '0, w);
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL abort_err_pulses: got %0d want 1", err_cnt); end
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL abort_valid_pulses: got %0d want 1", valid_cnt); end
        checks++; if (w !== 12'h3C7) begin errors++; $display("FAIL abort_next_sdo: got %h want 3c7", w); end
        checks++; if (cfg_chan !== 3'd0) begin errors++; $display("FAIL abort_cfg_chan: got %0d want 0", cfg_chan); end
    endtask

    // Differential word with S1 = 1, S0 = 1, O/S = 1 and UNI = 1.
    // Its channel field decodes to 6.
    task automatic test_diff();
        logic [11:0] w;
        set_ch(6, 12'hFFF);
        run_frame(6'b011110, 12, 1'b0, '0, w);
        checks++; if (w !== 12'h000) begin errors++; $display("FAIL diff_pre_sdo: got %h want 000", w); end
        checks++; if (cfg_chan !== 3'd6) begin errors++; $display("FAIL diff_cfg_chan: got %0d want 6", cfg_chan); end
        run_frame(6'b110010, 12, 1'b0, '0, w);
        checks++; if (w !== 12'hFFF) begin errors++; $display("FAIL diff_ch6_sdo: got %h want fff", w); end
        checks++; if (cfg_chan !== 3'd1) begin errors++; $display("FAIL diff_next_chan: got %0d want 1", cfg_chan); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] w;
        set_ch(0, 12'hA5C);
        clear_counts();
        run_frame(6'b100010, 7, 1'b0, '0, w);
        reset_n = 1'b0;
        wait_clks(3);
        checks++; if (ADC_SDO !== 1'b0) begin errors++; $display("FAIL rstmid_sdo: got %b want 0", ADC_SDO); end
        checks++; if (cfg_chan !== 3'd0) begin errors++; $display("FAIL rstmid_cfg_chan: got %0d want 0", cfg_chan); end
        reset_n = 1'b1;
        wait_clks(10);
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL rstmid_valid_pulses: got %0d want 0", valid_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL rstmid_err_pulses: got %0d want 0", err_cnt); end
        run_frame(6'b100010, 12, 1'b0, '0, w);
        checks++; if (w !== 12'hA5C) begin errors++; $display("FAIL rstmid_next_sdo: got %h want a5c", w); end
        checks++; if (valid_cnt != 1) begin errors++; $display("FAIL rstmid_next_valid: got %0d want 1", valid_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL rstmid_next_err: got %0d want 0", err_cnt); end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_chan_select();
        test_bipolar();
        test_abort();
        test_diff();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
